// File: rtl/mp3_pkg.sv
// rtl/mp3_pkg.sv - shared command codes, play modes, FSM states and shuffle LFSR constants
//
// Contents:
//   CMD_*       command byte codes delivered by the external UART receiver
//   mode_e      play mode encoding driven onto o_mode
//   state_e     command controller FSM states
//   LFSR_SEED   shuffle LFSR reset value
//   lfsr_step   one step of the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   vol_att     attenuation level to codec attenuation byte

package mp3_pkg;

    localparam logic [7:0] CMD_PAUSE    = 8'h01;
    localparam logic [7:0] CMD_NEXT     = 8'h02;
    localparam logic [7:0] CMD_PREV     = 8'h03;
    localparam logic [7:0] CMD_VOL_UP   = 8'h04;
    localparam logic [7:0] CMD_VOL_DN   = 8'h05;
    localparam logic [7:0] CMD_MODE     = 8'h06;
    localparam logic [7:0] CMD_SEL_BASE = 8'h40;

    typedef enum logic [1:0] {
        MODE_SEQ     = 2'd0,
        MODE_REPEAT  = 2'd1,
        MODE_SHUFFLE = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Right-shifting form: taps 16,14,13,11 land on bits 0,2,3,5.
    // Maximal length, so a non-zero seed never reaches the all-zero lock-up state.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // The quietest level maps to near-mute 0xFC instead of the linear value.
    function automatic logic [7:0] vol_att(input logic [3:0] level,
                                           input int        levels,
                                           input int        step);
        if (level == 4'(levels - 1)) begin
            return 8'hFC;
        end
        return 8'(step * int'(level));
    endfunction

endpackage

// File: rtl/bt_shuffle_lfsr.sv
// rtl/bt_shuffle_lfsr.sv - free-running 16-bit Fibonacci LFSR feeding shuffle selection
//
// Ports:
//   clk     sole clock
//   rst_n   asynchronous active-low reset, loads LFSR_SEED
//   o_lfsr  current LFSR state, advances every cycle

module bt_shuffle_lfsr
    import mp3_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] o_lfsr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_lfsr <= LFSR_SEED;
        end else begin
            o_lfsr <= lfsr_step(o_lfsr);
        end
    end

endmodule

// File: rtl/bt_cmd_ctrl.sv
// rtl/bt_cmd_ctrl.sv - Bluetooth MP3 player command controller (IDLE/EXEC/HOLD FSM)
//
// Ports:
//   clk             sole clock
//   rst_n           asynchronous active-low reset
//   i_rx_done       one-cycle strobe, i_rx_data valid
//   i_rx_data       command byte from the UART receiver
//   i_finish_song   current song ended, request auto-advance
//   o_song_select   current song index
//   o_vol_level     attenuation level, 0 = loudest
//   o_vol           {att,att} codec volume word
//   o_mode          0 sequential, 1 repeat-one, 2 shuffle
//   o_pause         pause state
//   o_next, o_pre, o_vol_plus, o_vol_dec   display flags, held through HOLD
//   o_busy          high while in HOLD

module bt_cmd_ctrl
    import mp3_pkg::*;
#(
    parameter int SONG_NUM    = 4,
    parameter int SEL_W       = $clog2(SONG_NUM),
    parameter int VOL_LEVELS  = 9,
    parameter int VOL_STEP    = 14,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_rx_done,
    input  logic [7:0]       i_rx_data,
    input  logic             i_finish_song,
    output logic [SEL_W-1:0] o_song_select,
    output logic [3:0]       o_vol_level,
    output logic [15:0]      o_vol,
    output logic [1:0]       o_mode,
    output logic             o_pause,
    output logic             o_next,
    output logic             o_pre,
    output logic             o_vol_plus,
    output logic             o_vol_dec,
    output logic             o_busy
);

    localparam int               CNT_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [SEL_W-1:0] LAST_SONG  = SEL_W'(SONG_NUM - 1);
    localparam logic [3:0]       LAST_LEVEL = 4'(VOL_LEVELS - 1);

    state_e           state;
    mode_e            mode;
    logic [SEL_W-1:0] song;
    logic [3:0]       level;
    logic [7:0]       exec_cmd;
    logic             exec_adv;
    logic [7:0]       pend_byte;
    logic             pend_byte_v;
    logic             pend_adv;
    logic [CNT_W-1:0] hold_cnt;
    logic [15:0]      lfsr;
    logic [7:0]       att;

    bt_shuffle_lfsr u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_lfsr (lfsr)
    );

    function automatic logic cmd_legal(input logic [7:0] c);
        if (c >= CMD_PAUSE && c <= CMD_MODE) begin
            return 1'b1;
        end
        if (c[7:6] == CMD_SEL_BASE[7:6]) begin
            return ({26'd0, c[5:0]} < 32'(SONG_NUM));
        end
        return 1'b0;
    endfunction

    function automatic logic [SEL_W-1:0] song_inc(input logic [SEL_W-1:0] s);
        return (s == LAST_SONG) ? '0 : s + SEL_W'(1);
    endfunction

    function automatic logic [SEL_W-1:0] song_dec(input logic [SEL_W-1:0] s);
        return (s == '0) ? LAST_SONG : s - SEL_W'(1);
    endfunction

    // Shuffle never replays the current song: a collision bumps to the next index.
    logic [SEL_W-1:0] shuf_cand;
    logic [SEL_W-1:0] shuf_pick;
    assign shuf_cand = SEL_W'(lfsr % 16'(SONG_NUM));
    assign shuf_pick = (shuf_cand == song) ? song_inc(shuf_cand) : shuf_cand;

    logic [SEL_W-1:0] next_song;
    logic [SEL_W-1:0] adv_song;
    assign next_song = (mode == MODE_SHUFFLE) ? shuf_pick : song_inc(song);

    always_comb begin
        adv_song = song;
        case (mode)
            MODE_SEQ:     adv_song = song_inc(song);
            MODE_SHUFFLE: adv_song = shuf_pick;
            default:      adv_song = song;
        endcase
    end

    logic rx_ok;
    assign rx_ok = i_rx_done && cmd_legal(i_rx_data);

    // Work selection in IDLE: pending slot first, then a fresh byte, then auto-advance.
    logic       src_go;
    logic       src_adv;
    logic       src_from_pend;
    logic [7:0] src_cmd;

    always_comb begin
        src_go        = 1'b0;
        src_adv       = 1'b0;
        src_from_pend = 1'b0;
        src_cmd       = i_rx_data;
        if (pend_byte_v) begin
            src_go        = 1'b1;
            src_from_pend = 1'b1;
            src_cmd       = pend_byte;
        end else if (pend_adv) begin
            src_go        = 1'b1;
            src_adv       = 1'b1;
            src_from_pend = 1'b1;
        end else if (rx_ok) begin
            src_go = 1'b1;
        end else if (i_finish_song) begin
            src_go  = 1'b1;
            src_adv = 1'b1;
        end
    end

    logic exec_to_hold;
    assign exec_to_hold = exec_adv
                       || (exec_cmd == CMD_NEXT)   || (exec_cmd == CMD_PREV)
                       || (exec_cmd == CMD_VOL_UP) || (exec_cmd == CMD_VOL_DN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            mode        <= MODE_SEQ;
            song        <= '0;
            level       <= '0;
            exec_cmd    <= '0;
            exec_adv    <= 1'b0;
            pend_byte   <= '0;
            pend_byte_v <= 1'b0;
            pend_adv    <= 1'b0;
            hold_cnt    <= '0;
            o_pause     <= 1'b0;
            o_next      <= 1'b0;
            o_pre       <= 1'b0;
            o_vol_plus  <= 1'b0;
            o_vol_dec   <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            // While busy, requests park in the one-entry slot; the newest byte wins
            // and an advance is only remembered if no byte is waiting.
            if (state != ST_IDLE) begin
                if (rx_ok) begin
                    pend_byte   <= i_rx_data;
                    pend_byte_v <= 1'b1;
                end
                if (i_finish_song && !pend_byte_v && !rx_ok) begin
                    pend_adv <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (src_go) begin
                        state      <= ST_EXEC;
                        exec_cmd   <= src_cmd;
                        exec_adv   <= src_adv;
                        o_next     <= !src_adv && (src_cmd == CMD_NEXT);
                        o_pre      <= !src_adv && (src_cmd == CMD_PREV);
                        o_vol_plus <= !src_adv && (src_cmd == CMD_VOL_UP);
                        o_vol_dec  <= !src_adv && (src_cmd == CMD_VOL_DN);
                    end
                    if (pend_byte_v) begin
                        pend_byte_v <= 1'b0;
                    end else if (pend_adv) begin
                        pend_adv <= 1'b0;
                    end
                    // Requests that lose arbitration this cycle are parked rather than dropped.
                    if (src_from_pend && rx_ok) begin
                        pend_byte   <= i_rx_data;
                        pend_byte_v <= 1'b1;
                    end
                    if (i_finish_song && (src_from_pend || rx_ok) && !(src_from_pend && rx_ok)) begin
                        pend_adv <= 1'b1;
                    end
                end

                ST_EXEC: begin
                    if (exec_adv) begin
                        song <= adv_song;
                    end else begin
                        case (exec_cmd)
                            CMD_NEXT: song <= next_song;
                            CMD_PREV: song <= song_dec(song);
                            CMD_VOL_UP: begin
                                if (level != '0) begin
                                    level <= level - 4'd1;
                                end
                            end
                            CMD_VOL_DN: begin
                                if (level != LAST_LEVEL) begin
                                    level <= level + 4'd1;
                                end
                            end
                            CMD_PAUSE: o_pause <= ~o_pause;
                            CMD_MODE: begin
                                case (mode)
                                    MODE_SEQ:    mode <= MODE_REPEAT;
                                    MODE_REPEAT: mode <= MODE_SHUFFLE;
                                    default:     mode <= MODE_SEQ;
                                endcase
                            end
                            // Only legal select codes are ever latched, so this is 0x40+n.
                            default: song <= SEL_W'(exec_cmd[5:0]);
                        endcase
                    end
                    if (exec_to_hold) begin
                        state    <= ST_HOLD;
                        hold_cnt <= '0;
                        o_busy   <= 1'b1;
                    end else begin
                        state      <= ST_IDLE;
                        o_next     <= 1'b0;
                        o_pre      <= 1'b0;
                        o_vol_plus <= 1'b0;
                        o_vol_dec  <= 1'b0;
                    end
                end

                ST_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state      <= ST_IDLE;
                        hold_cnt   <= '0;
                        o_busy     <= 1'b0;
                        o_next     <= 1'b0;
                        o_pre      <= 1'b0;
                        o_vol_plus <= 1'b0;
                        o_vol_dec  <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign att           = vol_att(level, VOL_LEVELS, VOL_STEP);
    assign o_vol         = {att, att};
    assign o_vol_level   = level;
    assign o_song_select = song;
    assign o_mode        = mode;

endmodule

// File: doc/bt_cmd_ctrl.md
BT_CMD_CTRL -- requirements
Module: bt_cmd_ctrl

Interface
REQ-001 Parameter SONG_NUM, default 4: number of songs, legal range 2..64.
REQ-002 Parameter SEL_W, default $clog2(SONG_NUM): song index width.
REQ-003 Parameter VOL_LEVELS, default 9: attenuation levels 0..VOL_LEVELS-1, 0 = loudest, legal range 2..16.
REQ-004 Parameter VOL_STEP, default 14: attenuation per level.
REQ-005 Parameter HOLD_CYCLES, default 50_000_000: post-command hold length in clk cycles, minimum 1.
REQ-006 Ports, in order:
- clk  input  1  sole clock.
- rst_n  input  1  reset, asynchronous, active-low.
- i_rx_done  input  1  one-cycle strobe; i_rx_data valid.
- i_rx_data  input  8  command byte.
- i_finish_song  input  1  current song ended.
- o_song_select  output  SEL_W  current song index.
- o_vol_level  output  4  attenuation level.
- o_vol  output  16  {att,att} codec volume word.
- o_mode  output  2  0 = sequential, 1 = repeat-one, 2 = shuffle.
- o_pause  output  1  pause state.
- o_next, o_pre, o_vol_plus, o_vol_dec  output  1 each  display flags.
- o_busy  output  1  high while in HOLD.

Function
REQ-007 Command codes: 0x01 pause toggle; 0x02 next; 0x03 previous; 0x04 volume up (level-1, floor 0); 0x05 volume down (level+1, ceiling VOL_LEVELS-1); 0x06 mode cycle 0->1->2->0; 0x40+n select song n. Any other byte, including 0x40+n with n>=SONG_NUM, is discarded with no state change.
REQ-008 FSM states: IDLE, EXEC, HOLD; reset state is IDLE.
REQ-009 IDLE: an accepted byte or auto-advance request is latched and the FSM moves to EXEC the next cycle. Source priority: pending slot, then i_rx_done, then i_finish_song.
REQ-010 EXEC lasts one cycle; the resulting outputs are visible on the cycle after EXEC, i.e. 2 cycles after the i_rx_done sample.
REQ-011 After EXEC, next/previous/volume/auto-advance go to HOLD; pause, mode and direct select return to IDLE.
REQ-012 HOLD lasts exactly HOLD_CYCLES cycles, then returns to IDLE; the counter clears on exit.
REQ-013 Next in modes 0/1: index+1, wrapping SONG_NUM-1 -> 0. Previous in all modes: index-1, wrapping 0 -> SONG_NUM-1.
REQ-014 Auto-advance: mode 0 as next; mode 1 keeps the index unchanged.
REQ-015 Shuffle (mode 2), for both next and auto-advance: candidate = lfsr mod SONG_NUM; if candidate equals the current index, use candidate+1 with wrap.
REQ-016 o_next is set in EXEC for next only, never for auto-advance. o_pre, o_vol_plus and o_vol_dec are set in EXEC for their commands. All four flags hold through HOLD and clear on entry to IDLE.
REQ-017 Volume mapping: att = 8'hFC when level == VOL_LEVELS-1, else (VOL_STEP*level) truncated to 8 bits; o_vol = {att,att}.
REQ-018 Pending slot, one entry:
- A valid byte received in EXEC or HOLD is stored; a later byte overwrites it (last wins).
- i_finish_song seen in EXEC/HOLD sets a separate pending-advance bit, stored only if no byte is pending.
- Pending work executes on the first IDLE cycle.
REQ-019 i_rx_done and i_finish_song together in IDLE: the byte executes; the advance becomes pending.
REQ-020 A 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1) advances every cycle and never reaches zero.

Reset
REQ-021 rst_n low, asynchronously: o_song_select=0, o_vol_level=0, o_mode=0, o_pause=0, all flags=0, o_busy=0, pending cleared, hold counter=0, LFSR=seed, state=IDLE.
REQ-022 Reset during HOLD or EXEC abandons the operation; nothing resumes after release.

Structure
REQ-023 Command codes, mode encodings and the LFSR seed/taps live in shared package mp3_pkg.
REQ-024 The LFSR is sub-module bt_shuffle_lfsr. The UART receiver stays outside the block and drives i_rx_done/i_rx_data.

Verification
REQ-025 Bench parameters: SONG_NUM=5, VOL_LEVELS=9, HOLD_CYCLES=8.
REQ-026 From reset, send 0x02 five times, each after o_busy falls -> index 1,2,3,4,0; o_next high for 9 cycles each time.
REQ-027 From reset, send 0x03 -> index 4; then send 0x44 -> index 4; then send 0x45 -> discarded, no state change.
REQ-028 Send 0x05 ten times -> level saturates at 8, o_vol=16'hFCFC; then send 0x04 -> level 7, o_vol=16'h6262.
REQ-029 During HOLD send 0x02 then 0x01 -> only pause toggles after HOLD ends; index advances once.
REQ-030 Mode 1, pulse i_finish_song -> index unchanged, o_next stays 0, o_busy high 8 cycles. Mode 2, 100 auto-advances -> every index in 0..4, never repeats the previous one.
REQ-031 Assert rst_n low mid-HOLD -> all outputs at reset values immediately; IDLE after release.
